// File: rtl/ibuff_ctrl.sv
// Instruction-buffer pointer/occupancy controller: compacts sparse fetch masks into
// RAM write slots, offers in-order dispatch groups. Optional macro: IBUFF_PARTIAL_DISPATCH_EN.
module ibuff_ctrl #(
  parameter int FETCH_WIDTH    = 2,
  parameter int DISPATCH_WIDTH = 2,
  parameter int WPORT          = 2 * FETCH_WIDTH,
  parameter int RPORT          = DISPATCH_WIDTH,
  parameter int DEPTH          = 16,
  parameter int INDEX          = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush_i,
  input  logic [WPORT-1:0]           fe_valid_i,
  output logic                       stall_o,
  output logic [WPORT-1:0]           we_o,
  output logic [WPORT*INDEX-1:0]     wr_addr_o,
  input  logic                       disp_ready_i,
  output logic                       disp_valid_o,
  output logic [$clog2(RPORT):0]     disp_cnt_o,
  output logic [RPORT*INDEX-1:0]     rd_addr_o,
  output logic [INDEX:0]             count_o
);

  localparam int              CW      = $clog2(RPORT) + 1;
  localparam logic [INDEX:0]  DEPTH_C = (INDEX+1)'(DEPTH);
  localparam logic [INDEX:0]  WPORT_C = (INDEX+1)'(WPORT);
  localparam logic [INDEX:0]  RPORT_C = (INDEX+1)'(RPORT);

  logic [INDEX-1:0] head;
  logic [INDEX-1:0] tail;
  logic [INDEX:0]   count;
  logic             acc;
  logic [INDEX:0]   push;
  logic [INDEX:0]   pop;
  logic             disp_valid;
  logic [CW-1:0]    disp_cnt;

  // Conservative: assumes a full bundle and ignores any same-cycle pop.
  assign stall_o = (DEPTH_C - count) < WPORT_C;
  assign acc     = (|fe_valid_i) & ~stall_o & ~flush_i;

  always_comb begin : compact
    logic [INDEX:0] ofs;
    // NOTE: every output of this block is defaulted first so no latch is inferred.
    ofs       = '0;
    we_o      = '0;
    wr_addr_o = '0;
    for (int i = 0; i < WPORT; i++) begin
      we_o[i]                     = fe_valid_i[i] & acc;
      wr_addr_o[i*INDEX +: INDEX] = tail + ofs[INDEX-1:0];
      ofs                         = ofs + (INDEX+1)'(fe_valid_i[i]);
    end
    push = acc ? ofs : '0;
  end

  always_comb begin
    rd_addr_o = '0;
    for (int k = 0; k < RPORT; k++) begin
      rd_addr_o[k*INDEX +: INDEX] = head + INDEX'(k);
    end
  end

`ifdef IBUFF_PARTIAL_DISPATCH_EN
  assign disp_valid = (count != '0);
  assign disp_cnt   = (count < RPORT_C) ? CW'(count) : CW'(RPORT);
`else
  assign disp_valid = (count >= RPORT_C);
  assign disp_cnt   = disp_valid ? CW'(RPORT) : '0;
`endif

  assign pop          = (disp_valid & disp_ready_i & ~flush_i) ? (INDEX+1)'(disp_cnt) : '0;
  assign disp_valid_o = disp_valid;
  assign disp_cnt_o   = disp_cnt;
  assign count_o      = count;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + push[INDEX-1:0];
      head  <= head + pop[INDEX-1:0];
      count <= count + push - pop;
    end
  end

endmodule

// File: tb/tb_ibuff_ctrl.sv
// Directed self-checking bench for ibuff_ctrl (WPORT=4, RPORT=2, DEPTH=16).
module tb_ibuff_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush_i;
  logic [3:0]  fe_valid_i;
  logic        stall_o;
  logic [3:0]  we_o;
  logic [15:0] wr_addr_o;
  logic        disp_ready_i;
  logic        disp_valid_o;
  logic [1:0]  disp_cnt_o;
  logic [7:0]  rd_addr_o;
  logic [4:0]  count_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ibuff_ctrl #(.WPORT(4), .RPORT(2), .DEPTH(16), .INDEX(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush_i(flush_i), .fe_valid_i(fe_valid_i),
    .stall_o(stall_o), .we_o(we_o), .wr_addr_o(wr_addr_o),
    .disp_ready_i(disp_ready_i), .disp_valid_o(disp_valid_o),
    .disp_cnt_o(disp_cnt_o), .rd_addr_o(rd_addr_o), .count_o(count_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Occupancy must stay within 0..DEPTH (an underflow would wrap above DEPTH).
  always @(negedge clk)
    if (reset_n) check("count_bound", {31'd0, count_o > 5'd16}, 32'd0);

  initial begin
    reset_n = 1'b0; flush_i = 1'b0; fe_valid_i = '0; disp_ready_i = 1'b0;
    step(); step();
    reset_n = 1'b1;
    #1;
    check("rst_count", count_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_we", we_o, 0);
    check("rst_dvalid", disp_valid_o, 0);
    check("rst_dcnt", disp_cnt_o, 0);
    check("rst_rdaddr", rd_addr_o, 8'h10);

    // Sparse mask at tail=0: lanes 1,3 -> addresses 0,1
    fe_valid_i = 4'b1010; #1;
    check("sparse_we", we_o, 4'b1010);
    check("sparse_wraddr", wr_addr_o, 16'h1100);
    step(); fe_valid_i = '0; #1;
    check("sparse_count", count_o, 2);
    check("sparse_dvalid", disp_valid_o, 1);
    check("sparse_dcnt", disp_cnt_o, 2);
    check("sparse_rdaddr", rd_addr_o, 8'h10);
    disp_ready_i = 1'b1;
    step(); disp_ready_i = 1'b0; #1;
    check("pop_count", count_o, 0);
    check("pop_rdaddr", rd_addr_o, 8'h32);

    // Fill from head=tail=2 with full masks and no dispatch
    fe_valid_i = 4'b1111; #1;
    check("fill_wraddr", wr_addr_o, 16'h5432);
    step(); step(); step(); #1;
    check("fill3_count", count_o, 12);
    check("fill3_stall", stall_o, 0);
    step(); #1;
    check("full_count", count_o, 16);
    check("full_stall", stall_o, 1);
    check("full_we", we_o, 0);
    step(); #1;
    check("full_hold", count_o, 16);

    // Drain to 12 so a push is acceptable again
    fe_valid_i = '0; disp_ready_i = 1'b1;
    step(); #1;
    check("drain_count", count_o, 14);
    check("drain_stall", stall_o, 1);
    step(); #1;
    check("drain2_count", count_o, 12);
    check("drain2_rdaddr", rd_addr_o, 8'h76);

    // Flush alongside a valid push and an acceptable pop
    fe_valid_i = 4'b1111; flush_i = 1'b1; #1;
    check("flush_we", we_o, 0);
    check("flush_dvalid", disp_valid_o, 1);
    step(); flush_i = 1'b0; disp_ready_i = 1'b0; fe_valid_i = 4'b0001; #1;
    check("flush_count", count_o, 0);
    check("flush_head", rd_addr_o, 8'h10);
    check("flush_tail", wr_addr_o, 16'h1110);
    check("post_flush_we", we_o, 4'b0001);
    fe_valid_i = '0; #1;

    // Walk head/tail to 14 with balanced push/pop
    fe_valid_i = 4'b0011; disp_ready_i = 1'b1;
    for (int n = 0; n < 7; n++) step();
    fe_valid_i = '0;
    step(); #1;
    check("walk_count", count_o, 0);
    check("walk_head", rd_addr_o, 8'hFE);

    // Wrap: push 4 at tail=14, then pop 2 twice
    disp_ready_i = 1'b0; fe_valid_i = 4'b1111; #1;
    check("wrap_wraddr", wr_addr_o, 16'h10FE);
    step(); fe_valid_i = '0; #1;
    check("wrap_count4", count_o, 4);
    check("wrap_rd0", rd_addr_o, 8'hFE);
    disp_ready_i = 1'b1;
    step(); #1;
    check("wrap_count2", count_o, 2);
    check("wrap_rd1", rd_addr_o, 8'h10);
    step(); disp_ready_i = 1'b0; #1;
    check("wrap_count0", count_o, 0);

    // Single entry: offer depends on partial-dispatch build
    fe_valid_i = 4'b0001;
    step(); fe_valid_i = '0; #1;
    check("one_count", count_o, 1);
`ifdef IBUFF_PARTIAL_DISPATCH_EN
    check("one_dvalid", disp_valid_o, 1);
    check("one_dcnt", disp_cnt_o, 1);
    disp_ready_i = 1'b1;
    step(); disp_ready_i = 1'b0; #1;
    check("one_popped", count_o, 0);
    fe_valid_i = 4'b0001;
    step(); fe_valid_i = '0; #1;
`else
    check("one_dvalid", disp_valid_o, 0);
    check("one_dcnt", disp_cnt_o, 0);
    disp_ready_i = 1'b1;
    step(); disp_ready_i = 1'b0; #1;
    check("one_held", count_o, 1);
`endif

    // Asynchronous reset mid-operation
    #2 reset_n = 1'b0; #1;
    check("arst_count", count_o, 0);
    check("arst_dvalid", disp_valid_o, 0);
    check("arst_rdaddr", rd_addr_o, 8'h10);
    step(); reset_n = 1'b1; #1;
    check("arst_release", count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
